// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer (P0..P7 per instruction) that owns HALT and decodes datapath strobes.
// Strobes depend only on registered state, opcode and zero flag; no backpressure, ena/resume start it.
module cpu_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       resume,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_acc,
    output logic       rd,
    output logic       wr,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] phase
);

    localparam logic [3:0] S_P0   = 4'd0;
    localparam logic [3:0] S_P1   = 4'd1;
    localparam logic [3:0] S_P2   = 4'd2;
    localparam logic [3:0] S_P3   = 4'd3;
    localparam logic [3:0] S_P4   = 4'd4;
    localparam logic [3:0] S_P5   = 4'd5;
    localparam logic [3:0] S_P6   = 4'd6;
    localparam logic [3:0] S_P7   = 4'd7;
    localparam logic [3:0] S_IDLE = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic [3:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       zero_q, zero_d;
    logic       alu_op;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: if (ena)    state_d = S_P0;
            S_HALT: if (resume) state_d = S_P0;
            S_P2: begin
                op_d    = opcode;
                state_d = S_P3;
            end
            S_P3: begin
                zero_d  = zero;
                state_d = (op_q == OP_HLT) ? S_HALT : S_P4;
            end
            S_P7:                                 state_d = S_P0;
            S_P0, S_P1, S_P4, S_P5, S_P6:         state_d = state_q + 4'd1;
            default:                              state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
        end
    end

    assign alu_op = (op_q == OP_ADD) || (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_LDA);

    // Pure decode of registered state, so an async reset drops every strobe at once.
    always_comb begin
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_ir     = 1'b0;
        load_acc    = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        phase       = state_q[3] ? 3'd0 : state_q[2:0];
        case (state_q)
            S_P0, S_P1: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
            end
            S_P3: halt = (op_q == OP_HLT);
            S_P4, S_P5: begin
                rd          = alu_op;
                datactl_ena = (op_q == OP_STO);
                wr          = (op_q == OP_STO) && (state_q == S_P5);
                load_pc     = (op_q == OP_JMP);
                inc_pc      = (op_q == OP_SKZ) && zero_q;
            end
            S_P6: begin
                rd          = alu_op;
                load_acc    = alu_op;
                datactl_ena = (op_q == OP_STO);
            end
            S_HALT: halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle expected strobe vectors go through a scoreboard queue.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst_n, ena, zero, resume;
    logic [2:0] opcode;
    logic       inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;
    logic [2:0] phase;
    logic [10:0] obs_v;
    logic [10:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_OP = 3'b011,
                           XOR_OP = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

    cpu_controller dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero), .resume(resume),
        .inc_pc(inc_pc), .load_pc(load_pc), .load_ir(load_ir), .load_acc(load_acc),
        .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .phase(phase)
    );

    always #5 clk = ~clk;

    assign obs_v = {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt, phase};

    // Expected {inc_pc,load_pc,load_ir,load_acc,rd,wr,datactl_ena,halt,phase} for one phase of an instruction.
    function automatic logic [10:0] model(input int ph, input logic [2:0] op, input logic z);
        logic inc, lpc, lir, lacc, r, w, dc, h, alu;
        logic [2:0] p;
        inc = 0; lpc = 0; lir = 0; lacc = 0; r = 0; w = 0; dc = 0; h = 0;
        p   = 3'(ph);
        alu = (op == ADD) || (op == AND_OP) || (op == XOR_OP) || (op == LDA);
        if (ph <= 1) begin r = 1; lir = 1; inc = 1; end
        if (ph == 3 && op == HLT) h = 1;
        if (alu && ph >= 4 && ph <= 6) r = 1;
        if (alu && ph == 6) lacc = 1;
        if (op == STO && ph >= 4 && ph <= 6) dc = 1;
        if (op == STO && ph == 5) w = 1;
        if (op == JMP && (ph == 4 || ph == 5)) lpc = 1;
        if (op == SKZ && z && (ph == 4 || ph == 5)) inc = 1;
        return {inc, lpc, lir, lacc, r, w, dc, h, p};
    endfunction

    task automatic chk(input string tag);
        logic [10:0] e;
        checks++;
        e = sb.pop_front();
        assert (obs_v === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_v, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs phases 0..nph-1 of one instruction; opcode/zero hold their real value only at the sampling phase.
    task automatic run_instr(input logic [2:0] op, input logic z, input int nph, input string tag);
        for (int ph = 0; ph < nph; ph++) begin
            opcode = (ph == 2) ? op : ~op;
            zero   = (ph == 3) ? z : ~z;
            ena    = ph[0];
            resume = ph[1];
            sb.push_back(model(ph, op, z));
            chk($sformatf("%s_p%0d", tag, ph));
            if (ph < nph - 1) tick();
        end
        if (nph > 0) tick();
    endtask

    initial begin
        rst_n = 0; ena = 0; zero = 0; resume = 0; opcode = 3'b000;
        @(negedge clk); @(negedge clk);
        sb.push_back(11'd0); chk("in_reset");
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            resume = i[0];
            sb.push_back(11'd0); chk("idle");
            tick();
        end
        resume = 0; ena = 1;
        sb.push_back(11'd0); chk("idle_ena");
        tick();

        run_instr(LDA,    1'b0, 8, "lda");
        run_instr(STO,    1'b1, 8, "sto");
        run_instr(SKZ,    1'b1, 8, "skz1");
        run_instr(SKZ,    1'b0, 8, "skz0");
        run_instr(JMP,    1'b0, 8, "jmp");
        run_instr(ADD,    1'b1, 8, "add");
        run_instr(HLT,    1'b0, 4, "hlt");

        for (int i = 0; i < 10; i++) begin
            ena = 1; resume = 0;
            sb.push_back(11'b000_0000_1000); chk("halt_hold");
            tick();
        end
        resume = 1;
        sb.push_back(11'b000_0000_1000); chk("halt_resume");
        tick();
        resume = 0;

        run_instr(STO, 1'b0, 5, "sto2");
        sb.push_back(model(5, STO, 1'b0)); chk("sto2_p5");
        rst_n = 0;
        #1;
        sb.push_back(11'd0); chk("reset_mid");
        @(negedge clk);
        rst_n = 1; ena = 0; resume = 0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(11'd0); chk("idle_after_reset");
            tick();
        end
        ena = 1;
        tick();
        run_instr(XOR_OP, 1'b0, 8, "xor");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
